mux_nx1_arb: RTL
================

Name: mux_nx1_arb

Overview:
- Parametrised N-to-1 data multiplexer; generalises the 2:1 combinational select into NCH arbitrated input channels.
- Each channel has a valid/ready handshake and a registered output stage.
- Arbitration is round-robin or fixed-priority, with optional packet lock on multi-beat transfers.
- Sits between parallel ecc_core datapath units (multiplier, adder, reduction lanes) and a shared consumer such as a result buffer or bus port.

Parameters:
- WIDTH, 32, data width per channel.
- NCH, 4, number of input channels (2..16).
- SELW, 2, width of the channel index; must equal ceil(log2(NCH)).
- MODE, 1, arbitration mode: 0 = fixed priority (channel 0 highest), 1 = round-robin.
- LOCK, 1, 1 = hold the grant on a channel until a beat with in_lst is accepted; 0 = re-arbitrate every beat.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_vld  input  NCH  per-channel valid; bit i belongs to channel i.
- in_lst  input  NCH  per-channel last-beat flag; ignored when LOCK=0.
- in_dat  input  NCH*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_rdy  output  NCH  per-channel ready; one-hot or zero.
- out_vld  output  1  output register holds valid data.
- out_lst  output  1  last flag of the beat held in the output register.
- out_dat  output  WIDTH  registered output data.
- out_sel  output  SELW  index of the channel that produced out_dat.
- out_rdy  input  1  consumer ready.
- busy  output  1  a packet lock is active.

Behaviour:
- Reset (async assert, sync release):
  - out_vld=0, out_lst=0, out_dat=0, out_sel=0, busy=0.
  - Round-robin pointer ptr=0; lock state = IDLE.
- Load condition: ld = ~out_vld | out_rdy. This makes the output register full-throughput; no bubble when out_rdy stays high.
- Grant gnt (combinational, one-hot or zero):
  - IDLE, MODE=0: lowest-index channel with in_vld set.
  - IDLE, MODE=1: first channel with in_vld set, scanning ptr, ptr+1, ... mod NCH.
  - LOCKED: gnt = lock channel only, even if other channels are valid.
- in_rdy[i] = gnt[i] & ld. in_rdy must never be asserted for a channel whose in_vld is low.
- Transfer on channel g happens when in_vld[g] & in_rdy[g]. On that edge:
  - out_dat <= in_dat[g], out_sel <= g, out_lst <= in_lst[g] (out_lst <= 1 when LOCK=0), out_vld <= 1.
- No transfer while ld=1: out_vld <= 0. While ld=0, the output register holds all fields stable.
- Latency: one cycle from input transfer to out_vld.
- Pointer update (MODE=1): ptr <= (g+1) mod NCH on each transfer that ends a packet (in_lst=1, or any transfer when LOCK=0). It is unchanged otherwise.
- Lock FSM (LOCK=1):
  - IDLE -> LOCKED(g) on a transfer with in_lst[g]=0.
  - LOCKED(g) -> IDLE on a transfer from g with in_lst[g]=1.
  - A single-beat packet (in_lst=1 on its first beat) stays in IDLE.
  - busy = (state == LOCKED).
  - If the locked channel drops in_vld, no other channel is granted; the grant holds until the packet completes.
- Simultaneous valid on all channels with MODE=1 and out_rdy held at 1: grants rotate 0,1,2,...,NCH-1,0, one per cycle.
- Dropping out_rdy mid-stream:
  - Output holds; in_rdy goes to 0 in the same cycle (combinational from out_rdy).
  - No data is lost or duplicated.
- Reset asserted mid-packet:
  - Lock state and ptr clear immediately; out_vld drops asynchronously.
  - The partial packet is abandoned; upstream must restart it.
- Width rule: out_sel is SELW wide. ptr wrap-around uses explicit compare against NCH-1, so non-power-of-2 NCH works.

Test Plan:
- Reset: hold rst_n=0 with all in_vld=1 -> out_vld=0, in_rdy=0000, busy=0; after release, the first grant goes to channel 0.
- Round-robin fairness: NCH=4, MODE=1, LOCK=0, in_vld=1111, in_dat[i]=0x10+i, out_rdy=1 -> out_dat sequence 0x10,0x11,0x12,0x13,0x10; out_vld continuous after the first cycle.
- Fixed priority: MODE=0, in_vld=0110 -> only channel 1 is served; channel 2 gets in_rdy only after in_vld[1] drops.
- Backpressure: out_rdy=0 for 3 cycles with out_vld=1 -> out_dat/out_sel stable, in_rdy=0000; on out_rdy=1, the next beat follows with no loss or duplication.
- Packet lock: channel 2 sends a 3-beat packet (lst on beat 3) while channel 0 is valid -> beats 1..3 from channel 2 are contiguous and busy=1 during the packet; next grant goes to channel 3, or to channel 0 if channel 3 is idle.
- Async reset mid-packet: assert rst_n low after beat 2 of a locked packet -> busy=0 and out_vld=0 immediately; after release, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/mux_nx1_arb.sv
// N-to-1 arbitrated multiplexer with valid/ready channels and a registered output stage.
// Supports fixed-priority or round-robin arbitration, with optional packet lock.
module mux_nx1_arb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2,
    parameter int unsigned MODE  = 1,
    parameter int unsigned LOCK  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_vld,
    input  logic [NCH-1:0]       in_lst,
    input  logic [NCH*WIDTH-1:0] in_dat,
    output logic [NCH-1:0]       in_rdy,
    output logic                 out_vld,
    output logic                 out_lst,
    output logic [WIDTH-1:0]     out_dat,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_rdy,
    output logic                 busy
);

    typedef enum logic {IDLE, LOCKED} lock_state_t;

    lock_state_t      state, state_nxt;
    logic [SELW-1:0]  lock_ch, lock_nxt;
    logic [SELW-1:0]  ptr;
    logic [NCH-1:0]   gnt;
    logic [SELW-1:0]  gidx;
    logic [WIDTH-1:0] sel_dat;
    logic             sel_lst;
    logic             found;
    logic             ld;
    logic             xfer;
    int unsigned      scan_idx;

    assign ld     = ~out_vld | out_rdy;
    assign in_rdy = rst_n ? (gnt & {NCH{ld}}) : '0;
    assign xfer   = |(in_vld & in_rdy);
    assign busy   = (state == LOCKED);

    // Grant: locked channel only while a packet is open, otherwise scan from the base index.
    always_comb begin
        gnt      = '0;
        gidx     = '0;
        sel_dat  = '0;
        sel_lst  = 1'b0;
        found    = 1'b0;
        scan_idx = 0;
        if (state == LOCKED) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (SELW'(i) == lock_ch) begin
                    gnt[i]  = in_vld[i];
                    gidx    = lock_ch;
                    sel_dat = in_dat[i*WIDTH +: WIDTH];
                    sel_lst = in_lst[i];
                end
            end
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                scan_idx = k + ((MODE != 0) ? 32'(ptr) : 32'd0);
                if (scan_idx >= NCH) scan_idx = scan_idx - NCH;
                if (!found && in_vld[scan_idx]) begin
                    found         = 1'b1;
                    gnt[scan_idx] = 1'b1;
                    gidx          = SELW'(scan_idx);
                    sel_dat       = in_dat[scan_idx*WIDTH +: WIDTH];
                    sel_lst       = in_lst[scan_idx];
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_ch;
        if ((LOCK != 0) && xfer) begin
            case (state)
                IDLE: begin
                    if (!sel_lst) begin
                        state_nxt = LOCKED;
                        lock_nxt  = gidx;
                    end
                end
                LOCKED: begin
                    if (sel_lst) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lock_ch <= '0;
        end else begin
            state   <= state_nxt;
            lock_ch <= lock_nxt;
        end
    end

    // Pointer advances past the granted channel only when a packet ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if ((MODE != 0) && xfer && ((LOCK == 0) || sel_lst)) begin
            if (gidx == SELW'(NCH - 1)) ptr <= '0;
            else                         ptr <= gidx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_lst <= 1'b0;
            out_dat <= '0;
            out_sel <= '0;
        end else if (ld) begin
            if (xfer) begin
                out_vld <= 1'b1;
                out_lst <= (LOCK != 0) ? sel_lst : 1'b1;
                out_dat <= sel_dat;
                out_sel <= gidx;
            end else begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule
